// File: rtl/fma16_issue_arb.sv
// fma16_issue_arb: round-robin issue arbiter sharing one fma16 core, with tag pipe, response FIFO and sticky flags.
// Latency: handshake in cycle T -> fma_valid in T+1 -> rsp_valid in T+1+LATENCY (empty FIFO); one issue per cycle.
// Backpressure: no grant unless buffered + in-flight ops (net of this cycle's pop) leave a FIFO slot; results never drop.
// Option: define FMA16_ARB_PRIO_EN to give requester 0 strict priority (others stay round-robin).
module fma16_issue_arb #(
   parameter int NREQ    = 4,
   parameter int LATENCY = 2,
   parameter int IDW     = $clog2(NREQ)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [16*NREQ-1:0]  req_x,
   input  logic [16*NREQ-1:0]  req_y,
   input  logic [16*NREQ-1:0]  req_z,
   input  logic [4*NREQ-1:0]   req_ctrl,
   input  logic [2*NREQ-1:0]   req_roundmode,
   output logic                fma_valid,
   output logic [15:0]         fma_x,
   output logic [15:0]         fma_y,
   output logic [15:0]         fma_z,
   output logic [3:0]          fma_ctrl,
   output logic [1:0]          fma_roundmode,
   input  logic [15:0]         fma_result,
   input  logic [3:0]          fma_flags,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [15:0]         rsp_result,
   output logic [3:0]          rsp_flags,
   input  logic                flags_clr,
   output logic [3:0]          sticky_flags
);

   // FIFO depth covers every op that can be in the core plus one being drained
   localparam int D  = LATENCY + 1;
   localparam int PW = $clog2(D);
   localparam int OW = $clog2(D + 1);
   localparam int CW = $clog2(D + LATENCY + 1);
   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     ptr_nxt;
   logic               sel_found;
   logic [IDW-1:0]     sel_id;
   logic [IDW:0]       cand;
   logic [IDW:0]       nxt_w;
   logic               issue_ok;
   logic               grant;
   logic [CW-1:0]      inflight;
   logic [CW-1:0]      credit_used;

   logic [LATENCY-1:0] tag_vld;
   logic [IDW-1:0]     tag_id [LATENCY];
   logic               push;
   logic               pop;

   logic [IDW-1:0]     q_id  [D];
   logic [15:0]        q_res [D];
   logic [3:0]         q_flg [D];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [OW-1:0]      occ;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(D - 1)) ? '0 : p + 1'b1;
   endfunction

   // Pick the first valid requester at or after ptr (requester 0 first when priority is enabled)
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr} + (IDW+1)'(k);
         if (cand >= NREQ_W) cand = cand - NREQ_W;
         if (!sel_found && req_valid[cand[IDW-1:0]]) begin
            sel_found = 1'b1;
            sel_id    = cand[IDW-1:0];
         end
      end
`ifdef FMA16_ARB_PRIO_EN
      if (req_valid[0]) begin
         sel_found = 1'b1;
         sel_id    = '0;
      end
`endif
   end

   // Next pointer is one past the granted requester, wrapping at NREQ
   always_comb begin
      nxt_w = {1'b0, sel_id} + 1'b1;
      if (nxt_w >= NREQ_W) nxt_w = '0;
      ptr_nxt = nxt_w[IDW-1:0];
   end

   // Buffered plus in-flight ops, net of this cycle's pop, must leave a slot for the new op
   always_comb begin
      inflight = '0;
      for (int k = 0; k < LATENCY; k++) inflight = inflight + CW'(tag_vld[k]);
      credit_used = CW'(occ) + inflight - CW'(pop);
      issue_ok    = reset_n && (credit_used < CW'(D));
   end

   assign grant = issue_ok & sel_found;

   // One-hot grant to the selected requester when credits allow
   always_comb begin
      req_ready = '0;
      if (grant) req_ready[sel_id] = 1'b1;
   end

   // Round-robin pointer advances past each grant (requester-0 priority grants leave it alone)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
`ifdef FMA16_ARB_PRIO_EN
      end else if (grant && (sel_id != '0)) begin
`else
      end else if (grant) begin
`endif
         ptr <= ptr_nxt;
      end
   end

   // Registered core issue; operands hold when nothing is granted
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fma_valid     <= 1'b0;
         fma_x         <= '0;
         fma_y         <= '0;
         fma_z         <= '0;
         fma_ctrl      <= '0;
         fma_roundmode <= '0;
      end else begin
         fma_valid <= grant;
         for (int k = 0; k < NREQ; k++) begin
            if (req_ready[k]) begin
               fma_x         <= req_x[16*k +: 16];
               fma_y         <= req_y[16*k +: 16];
               fma_z         <= req_z[16*k +: 16];
               fma_ctrl      <= req_ctrl[4*k +: 4];
               fma_roundmode <= req_roundmode[2*k +: 2];
            end
         end
      end
   end

   // Tag pipe launched with fma_valid; its last stage lines up with the core result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tag_vld <= '0;
         for (int k = 0; k < LATENCY; k++) tag_id[k] <= '0;
      end else begin
         tag_vld[0] <= grant;
         tag_id[0]  <= sel_id;
         for (int k = 1; k < LATENCY; k++) begin
            tag_vld[k] <= tag_vld[k-1];
            tag_id[k]  <= tag_id[k-1];
         end
      end
   end

   assign push       = tag_vld[LATENCY-1];
   assign rsp_valid  = (occ != '0);
   assign pop        = rsp_valid & rsp_ready;
   assign rsp_id     = q_id[rd_ptr];
   assign rsp_result = q_res[rd_ptr];
   assign rsp_flags  = q_flg[rd_ptr];

   // Circular response FIFO; storage is cleared so an empty head reads as zero after reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
         for (int k = 0; k < D; k++) begin
            q_id[k]  <= '0;
            q_res[k] <= '0;
            q_flg[k] <= '0;
         end
      end else begin
         if (push) begin
            q_id[wr_ptr]  <= tag_id[LATENCY-1];
            q_res[wr_ptr] <= fma_result;
            q_flg[wr_ptr] <= fma_flags;
            wr_ptr        <= wrap_inc(wr_ptr);
         end
         if (pop) rd_ptr <= wrap_inc(rd_ptr);
         occ <= occ + OW'(push) - OW'(pop);
      end
   end

   // Sticky exception flags; a push in the clear cycle survives the clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sticky_flags <= '0;
      else          sticky_flags <= (flags_clr ? 4'b0000 : sticky_flags) | (push ? fma_flags : 4'b0000);
   end

   // Credit accounting must make a push into a full FIFO impossible
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
                                   !(push && (occ == OW'(D)) && !pop));

endmodule

// File: tb/tb_fma16_issue_arb.sv
// Bench for fma16_issue_arb: directed stimulus, an op-queue model of the arbiter and a simple core model.
`timescale 1ns/1ps
module tb_fma16_issue_arb;
   localparam int NREQ    = 4;
   localparam int LATENCY = 2;
   localparam int IDW     = 2;
   localparam int D       = LATENCY + 1;
`ifdef FMA16_ARB_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                reset_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [16*NREQ-1:0]  req_x, req_y, req_z;
   logic [4*NREQ-1:0]   req_ctrl;
   logic [2*NREQ-1:0]   req_roundmode;
   logic                fma_valid;
   logic [15:0]         fma_x, fma_y, fma_z;
   logic [3:0]          fma_ctrl;
   logic [1:0]          fma_roundmode;
   logic [15:0]         fma_result;
   logic [3:0]          fma_flags;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [15:0]         rsp_result;
   logic [3:0]          rsp_flags;
   logic                flags_clr;
   logic [3:0]          sticky_flags;

   logic [15:0] rx [NREQ];
   logic [15:0] ry [NREQ];
   logic [15:0] rz [NREQ];
   logic [3:0]  rc [NREQ];
   logic [1:0]  rrm [NREQ];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NREQ; g++) begin : g_pack
      assign req_x[16*g +: 16]       = rx[g];
      assign req_y[16*g +: 16]       = ry[g];
      assign req_z[16*g +: 16]       = rz[g];
      assign req_ctrl[4*g +: 4]      = rc[g];
      assign req_roundmode[2*g +: 2] = rrm[g];
   end

   fma16_issue_arb #(.NREQ(NREQ), .LATENCY(LATENCY)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y), .req_z(req_z),
      .req_ctrl(req_ctrl), .req_roundmode(req_roundmode),
      .fma_valid(fma_valid), .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
      .fma_ctrl(fma_ctrl), .fma_roundmode(fma_roundmode),
      .fma_result(fma_result), .fma_flags(fma_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .flags_clr(flags_clr), .sticky_flags(sticky_flags)
   );

   // Core stand-in: known fp16 answers for the directed vectors, an arbitrary mix otherwise
   function automatic logic [19:0] core_fn(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                                           input logic [3:0] c, input logic [1:0] rm);
      if (x == 16'h3C00 && y == 16'h4000 && z == 16'h3C00) return {4'b0000, 16'h4200};
      if (x == 16'h7BFF && y == 16'h4000 && z == 16'h0000) return {4'b0101, 16'h7C00};
      if (x == 16'h3C01 && y == 16'h3C01 && z == 16'h0000) return {4'b0001, 16'h3C02};
      return {4'b0000, x + y + z + {12'h000, c} + {14'h0000, rm}};
   endfunction

   // LATENCY-1 register stages after the cycle fma_valid is seen
   logic [19:0] core_pipe;
   always @(posedge clk) core_pipe <= core_fn(fma_x, fma_y, fma_z, fma_ctrl, fma_roundmode);
   assign fma_result = core_pipe[15:0];
   assign fma_flags  = core_pipe[19:16];

   int tests;
   int fails;
   int cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int gidx(input logic [NREQ-1:0] rr);
      int r;
      r = -1;
      for (int i = 0; i < NREQ; i++) if (rr[i]) r = (r == -1) ? i : -2;
      return r;
   endfunction

   // Model: every granted op is outstanding until popped and becomes visible 1+LATENCY cycles after its grant
   typedef struct {
      int          id;
      logic [15:0] res;
      logic [3:0]  flg;
      int          ready;
   } op_t;

   op_t         mq[$];
   op_t         new_op;
   logic [19:0] r_tmp;
   int          m_ptr;
   int          m_gid;
   logic        m_pop;
   logic        head_rdy;
   logic [3:0]  exp_rr;
   logic        m_fv;
   logic [15:0] m_fx, m_fy, m_fz;
   logic [3:0]  m_fc;
   logic [1:0]  m_frm;
   logic [3:0]  m_sticky;

   // Compare DUT outputs against the model every cycle, away from the clock edge
   always @(negedge clk) begin
      if (!reset_n) begin
         mq.delete();
         m_ptr = 0; m_gid = -1; m_pop = 1'b0; m_fv = 1'b0;
         m_fx = '0; m_fy = '0; m_fz = '0; m_fc = '0; m_frm = '0; m_sticky = '0;
         check("rst_req_ready", req_ready, 0);
         check("rst_fma_valid", fma_valid, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_sticky", sticky_flags, 0);
      end else begin
         head_rdy = (mq.size() > 0) && (mq[0].ready <= cyc);
         m_pop    = head_rdy && rsp_ready;
         m_gid    = -1;
         if ((mq.size() - int'(m_pop)) < D) begin
            if (PRIO && req_valid[0]) m_gid = 0;
            for (int d = 0; d < NREQ; d++)
               if (m_gid < 0 && req_valid[(m_ptr + d) % NREQ]) m_gid = (m_ptr + d) % NREQ;
         end
         exp_rr = '0;
         if (m_gid >= 0) exp_rr[m_gid] = 1'b1;
         check("req_ready", req_ready, exp_rr);
         check("fma_valid", fma_valid, m_fv);
         check("fma_x", fma_x, m_fx);
         check("fma_y", fma_y, m_fy);
         check("fma_z", fma_z, m_fz);
         check("fma_ctrl", fma_ctrl, m_fc);
         check("fma_roundmode", fma_roundmode, m_frm);
         check("rsp_valid", rsp_valid, head_rdy);
         if (head_rdy) begin
            check("rsp_id", rsp_id, mq[0].id);
            check("rsp_result", rsp_result, mq[0].res);
            check("rsp_flags", rsp_flags, mq[0].flg);
         end
         check("sticky_flags", sticky_flags, m_sticky);
      end
   end

   // Advance the model at the clock edge using the decisions taken for this cycle
   always @(posedge clk) begin
      if (reset_n) begin
         if (flags_clr) m_sticky = '0;
         foreach (mq[k]) if (mq[k].ready == cyc + 1) m_sticky = m_sticky | mq[k].flg;
         if (m_pop) void'(mq.pop_front());
         if (m_gid >= 0) begin
            r_tmp        = core_fn(rx[m_gid], ry[m_gid], rz[m_gid], rc[m_gid], rrm[m_gid]);
            new_op.id    = m_gid;
            new_op.res   = r_tmp[15:0];
            new_op.flg   = r_tmp[19:16];
            new_op.ready = cyc + 1 + LATENCY;
            mq.push_back(new_op);
            m_fv = 1'b1;
            m_fx = rx[m_gid]; m_fy = ry[m_gid]; m_fz = rz[m_gid]; m_fc = rc[m_gid]; m_frm = rrm[m_gid];
            if (!(PRIO && m_gid == 0)) m_ptr = (m_gid + 1) % NREQ;
         end else begin
            m_fv = 1'b0;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                          input logic [3:0] c, input logic [1:0] rm);
      rx[i] = x; ry[i] = y; rz[i] = z; rc[i] = c; rrm[i] = rm;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int nrsp;
   int ngr;

   initial begin
      tests = 0; fails = 0;
      reset_n = 1'b0; rsp_ready = 1'b1; flags_clr = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, '0, '0, '0, '0, '0);
      req_valid = 4'hF;
      tick(); tick();
      // Reset state with requests pending
      check("lit_rst_req_ready", req_ready, 0);
      check("lit_rst_fma_x", fma_x, 0);
      check("lit_rst_rsp_id", rsp_id, 0);
      check("lit_rst_rsp_result", rsp_result, 0);
      req_valid = '0;
      reset_n = 1'b1;

      // Single op from requester 2: 1*2+1 = 3
      tick();
      set_req(2, 16'h3C00, 16'h4000, 16'h3C00, 4'b1100, 2'b00);
      req_valid = 4'b0100;
      @(negedge clk); check("lit_t1_grant", req_ready, 4'b0100);
      tick(); req_valid = '0;
      @(negedge clk); check("lit_t1_fma_valid", fma_valid, 1); check("lit_t1_fma_x", fma_x, 16'h3C00);
      check("lit_t1_fma_ctrl", fma_ctrl, 4'b1100);
      tick();
      @(negedge clk); check("lit_t1_rsp_early", rsp_valid, 0);
      tick();
      @(negedge clk);
      check("lit_t1_rsp_valid", rsp_valid, 1); check("lit_t1_rsp_id", rsp_id, 2);
      check("lit_t1_rsp_result", rsp_result, 16'h4200); check("lit_t1_rsp_flags", rsp_flags, 0);
      tick();

      // All four requesters continuously valid, consumer always ready
      do_reset();
      for (int i = 0; i < NREQ; i++)
         set_req(i, 16'h1000 + 16'(i) * 16'h0111, 16'h2000 + 16'(i), 16'h0300 + 16'(i), 4'b1100, 2'(i));
      req_valid = 4'hF;
      nrsp = 0;
      for (int c = 0; c < 17; c++) begin
         if (c == 12) req_valid = '0;
         @(negedge clk);
         if (c < 12) check("lit_t2_grant_order", gidx(req_ready), PRIO ? 0 : c % 4);
         if (rsp_valid) begin
            check("lit_t2_rsp_order", rsp_id, PRIO ? 0 : nrsp % 4);
            nrsp++;
         end
         tick();
      end
      check("lit_t2_rsp_count", nrsp, 12);

      // Consumer stalled: only D ops may be granted, then resume as a slot frees
      do_reset();
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      ngr = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (req_ready != '0) ngr++;
         tick();
      end
      check("lit_t3_grant_count", ngr, 3);
      @(negedge clk); check("lit_t3_ready_low", req_ready, 0);
      tick();
      rsp_ready = 1'b1;
      nrsp = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) check("lit_t3_resume", gidx(req_ready), PRIO ? 0 : 3);
         if (rsp_valid) begin
            check("lit_t3_drain_order", rsp_id, PRIO ? 0 : nrsp);
            nrsp++;
         end
         tick();
         if (c == 0) req_valid = '0;
      end
      check("lit_t3_drain_count", nrsp, 4);

      // Overflow result, then a clear racing an inexact-only push
      do_reset();
      set_req(1, 16'h7BFF, 16'h4000, 16'h0000, 4'b1100, 2'b00);
      req_valid = 4'b0010;
      tick(); req_valid = '0;
      tick(); tick();
      @(negedge clk);
      check("lit_t4_result", rsp_result, 16'h7C00); check("lit_t4_flags", rsp_flags, 4'b0101);
      check("lit_t4_sticky", sticky_flags, 4'b0101);
      tick();
      set_req(1, 16'h3C01, 16'h3C01, 16'h0000, 4'b1100, 2'b00);
      req_valid = 4'b0010;
      tick(); req_valid = '0;
      tick(); flags_clr = 1'b1;
      tick(); flags_clr = 1'b0;
      @(negedge clk);
      check("lit_t4_sticky_after_clr", sticky_flags, 4'b0001); check("lit_t4_inexact_result", rsp_result, 16'h3C02);
      tick(); flags_clr = 1'b1;
      tick(); flags_clr = 1'b0;
      @(negedge clk); check("lit_t4_sticky_cleared", sticky_flags, 0);
      tick();

      // Reset with two ops in flight and one buffered
      do_reset();
      rsp_ready = 1'b0;
      set_req(0, 16'h7BFF, 16'h4000, 16'h0000, 4'b1100, 2'b00);
      req_valid = 4'b0111;
      tick(); tick(); tick();
      @(negedge clk);
      check("lit_t5_buffered", rsp_valid, 1); check("lit_t5_sticky_pre", sticky_flags, 4'b0101);
      #1 reset_n = 1'b0;
      #1;
      check("lit_t5_rsp_valid_rst", rsp_valid, 0); check("lit_t5_sticky_rst", sticky_flags, 0);
      tick(); tick();
      req_valid = '0; rsp_ready = 1'b1; reset_n = 1'b1;
      nrsp = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (rsp_valid) nrsp++;
         tick();
      end
      check("lit_t5_no_rsp", nrsp, 0);
      req_valid = 4'hF;
      @(negedge clk); check("lit_t5_first_grant", gidx(req_ready), 0);
      tick(); req_valid = '0;
      repeat (4) tick();

      // Requesters 0 and 3 contending with ptr at 3
      do_reset();
      set_req(2, 16'h1234, 16'h0001, 16'h0002, 4'b1000, 2'b01);
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b1001;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("lit_t6_contend", gidx(req_ready), PRIO ? 0 : ((c == 1) ? 0 : 3));
         tick();
      end
      req_valid = 4'b1000;
      @(negedge clk); check("lit_t6_after_r0_drop", gidx(req_ready), 3);
      tick(); req_valid = '0;
      repeat (6) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
